// File: rtl/izayoi_pkg.sv
// Shared types and helpers for the random-number consumer blocks.
// Holds the sampler FSM states and the rejection-sampling mask function.
package izayoi_pkg;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_IDLE,
    ST_SAMPLE
  } state_t;

  // A zero seed would lock the LFSR in its all-zero state forever.
  localparam logic [7:0] RAND_ZERO_SUB = 8'h01;

  // Smallest 2^k-1 covering limit-1; limit 0 stands for 256, so limit-1 wraps to 255.
  function automatic logic [7:0] rand_mask(input logic [7:0] limit);
    logic [7:0] m;
    m = limit - 8'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

// File: rtl/rand_range_sampler.sv
// Turns the raw LFSR byte stream into uniform values in [0, limit) by masked
// rejection sampling with a bounded retry count; also owns the generator's seeding.
module rand_range_sampler
  import izayoi_pkg::*;
#(
  parameter logic [7:0]  SEED      = 8'hF0,
  parameter int unsigned MAX_TRIES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rand_byte,
  output logic       rand_load,
  output logic [7:0] rand_seed,
  input  logic       reseed,
  input  logic [7:0] seed_in,
  input  logic       req,
  input  logic [7:0] limit,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] value
);

  localparam logic [3:0] TRIES = 4'(MAX_TRIES);

  state_t     state, state_next;
  logic [3:0] try_cnt, try_cnt_next, try_inc;
  logic [8:0] lim, lim_next;
  logic [7:0] mask, mask_next;
  logic [8:0] cand;
  logic [7:0] value_next, rand_seed_next;
  logic       out_valid_next, rand_load_next;

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_next     = state;
    try_cnt_next   = try_cnt;
    lim_next       = lim;
    mask_next      = mask;
    value_next     = value;
    out_valid_next = 1'b0;
    rand_load_next = 1'b0;
    rand_seed_next = rand_seed;
    cand           = {1'b0, rand_byte & mask};
    try_inc        = try_cnt + 4'd1;

    case (state)
      ST_SEED: begin
        rand_load_next = 1'b1;
        rand_seed_next = SEED;
        state_next     = ST_IDLE;
      end
      ST_IDLE: begin
        if (req) begin
          lim_next     = (limit == 8'd0) ? 9'd256 : {1'b0, limit};
          mask_next    = rand_mask(limit);
          try_cnt_next = 4'd0;
          state_next   = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        try_cnt_next = try_inc;
        if (cand < lim) begin
          value_next     = cand[7:0];
          out_valid_next = 1'b1;
          state_next     = ST_IDLE;
        end else if (try_inc >= TRIES) begin
          // mask < 2*limit, so a rejected candidate minus limit always lands in range.
          value_next     = 8'(cand - lim);
          out_valid_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_SEED;
    endcase

    // A reseed request overrides the power-up seed and never disturbs the FSM.
    if (reseed) begin
      rand_load_next = 1'b1;
      rand_seed_next = (seed_in == 8'd0) ? RAND_ZERO_SUB : seed_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SEED;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      try_cnt   <= 4'd0;
      lim       <= 9'd0;
      mask      <= 8'd0;
      value     <= 8'd0;
      out_valid <= 1'b0;
      rand_load <= 1'b0;
      rand_seed <= SEED;
    end else begin
      try_cnt   <= try_cnt_next;
      lim       <= lim_next;
      mask      <= mask_next;
      value     <= value_next;
      out_valid <= out_valid_next;
      rand_load <= rand_load_next;
      rand_seed <= rand_seed_next;
    end
  end

endmodule

// File: tb/tb_rand_range_sampler.sv
// Scoreboard bench for rand_range_sampler: the driver pushes reference results,
// a negedge monitor pops and compares them whenever out_valid pulses.
module tb_rand_range_sampler;

  localparam int MT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rand_byte = 8'd0;
  logic       rand_load;
  logic [7:0] rand_seed;
  logic       reseed = 1'b0;
  logic [7:0] seed_in = 8'd0;
  logic       req = 1'b0;
  logic [7:0] limit = 8'd0;
  logic       busy;
  logic       out_valid;
  logic [7:0] value;

  rand_range_sampler #(.SEED(8'hF0), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst_n(rst_n), .rand_byte(rand_byte),
    .rand_load(rand_load), .rand_seed(rand_seed),
    .reseed(reseed), .seed_in(seed_in),
    .req(req), .limit(limit),
    .busy(busy), .out_valid(out_valid), .value(value)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [7:0]  val;
    int unsigned due;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] stim[MT];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid: actual value=0x%0h required=no result", value);
      end else begin
        mon_e = sb.pop_front();
        check_output("value", 32'(value), 32'(mon_e.val));
        check_output("latency", cycle, mon_e.due);
      end
    end
  end

  // Reference: uniform draw in [0,L) from the bytes offered on each attempt.
  function automatic void model(input int lim8, output logic [7:0] v, output int n);
    int l, m, c;
    l = (lim8 == 0) ? 256 : lim8;
    m = 0;
    while (m < l - 1) m = m * 2 + 1;
    c = 0;
    for (int i = 0; i < MT; i++) begin
      c = int'(stim[i]) & m;
      if (c < l) begin
        v = 8'(c);
        n = i + 1;
        return;
      end
    end
    v = 8'(c - l);
    n = MT;
  endfunction

  task automatic reset_and_seed(input bit rs, input logic [7:0] s);
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0;
    reseed = 1'b0;
    #1;
    check_output("rst_busy", 32'(busy), 32'd1);
    check_output("rst_load", 32'(rand_load), 32'd0);
    check_output("rst_seed", 32'(rand_seed), 32'hF0);
    check_output("rst_valid", 32'(out_valid), 32'd0);
    check_output("rst_value", 32'(value), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reseed = rs;
    seed_in = s;
    @(posedge clk); #1;
    reseed = 1'b0;
    check_output("seed_load", 32'(rand_load), 32'd1);
    check_output("seed_value", 32'(rand_seed), rs ? 32'(s) : 32'hF0);
    check_output("seed_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_output("seed_load_end", 32'(rand_load), 32'd0);
  endtask

  // rs_at: -1 none, 0 together with req, k>0 during attempt k-1.
  task automatic apply_stimulus(input logic [7:0] lim8, input bit poke, input int rs_at,
                                input logic [7:0] rs_seed, input bit abort);
    logic [7:0]  v;
    int          n, waited;
    int unsigned acc;
    exp_t        e;
    logic [7:0]  want_seed;
    want_seed = (rs_seed == 8'd0) ? 8'h01 : rs_seed;
    @(negedge clk);
    waited = 0;
    while (busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL busy_timeout: actual busy=1 required busy=0");
      return;
    end
    model(int'(lim8), v, n);
    req = 1'b1;
    limit = lim8;
    reseed = (rs_at == 0);
    seed_in = rs_seed;
    @(posedge clk); #1;
    acc = cycle;
    req = 1'b0;
    reseed = 1'b0;
    if (rs_at == 0) begin
      check_output("reseed_idle_load", 32'(rand_load), 32'd1);
      check_output("reseed_idle_seed", 32'(rand_seed), 32'(want_seed));
    end
    if (!abort) begin
      e.val = v;
      e.due = acc + 32'(n);
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      rand_byte = stim[i];
      if (abort && i == 1) begin
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", 32'(busy), 32'd1);
        check_output("abort_valid", 32'(out_valid), 32'd0);
        check_output("abort_value", 32'(value), 32'd0);
        check_output("abort_seed", 32'(rand_seed), 32'hF0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("abort_reload", 32'(rand_load), 32'd1);
        check_output("abort_reseed", 32'(rand_seed), 32'hF0);
        check_output("abort_value_after", 32'(value), 32'd0);
        return;
      end
      if (poke && i == 1) begin
        req = 1'b1;
        limit = 8'h01;
      end
      if (i + 1 == rs_at) begin
        reseed = 1'b1;
        seed_in = rs_seed;
      end
      @(posedge clk); #1;
      req = 1'b0;
      reseed = 1'b0;
      if (i + 1 == rs_at) begin
        check_output("reseed_load", 32'(rand_load), 32'd1);
        check_output("reseed_seed", 32'(rand_seed), 32'(want_seed));
      end
      if (i == rs_at) check_output("reseed_load_end", 32'(rand_load), 32'd0);
    end
  endtask

  task automatic set_stim(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d);
    stim[0] = a;
    stim[1] = b;
    stim[2] = c;
    stim[3] = d;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] lim_r;
    reset_and_seed(1'b0, 8'h00);

    set_stim(8'h07, 8'h0E, 8'h03, 8'h00);
    apply_stimulus(8'd5, 1'b0, -1, 8'h00, 1'b0);
    set_stim(8'h07, 8'h07, 8'h07, 8'h07);
    apply_stimulus(8'd5, 1'b0, -1, 8'h00, 1'b0);
    set_stim(8'hFF, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'd0, 1'b0, -1, 8'h00, 1'b0);
    set_stim(8'($urandom), 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'd1, 1'b0, -1, 8'h00, 1'b0);
    set_stim(8'hC5, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'd128, 1'b0, -1, 8'h00, 1'b0);

    set_stim(8'h07, 8'h07, 8'h07, 8'h07);
    apply_stimulus(8'd5, 1'b0, 2, 8'h00, 1'b0);
    apply_stimulus(8'd5, 1'b1, -1, 8'h00, 1'b0);
    set_stim(8'hF5, 8'h10, 8'h00, 8'h00);
    apply_stimulus(8'd200, 1'b0, 0, 8'h5A, 1'b0);

    set_stim(8'hC5, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'd128, 1'b0, -1, 8'h00, 1'b0);
    set_stim(8'h07, 8'h07, 8'h07, 8'h07);
    apply_stimulus(8'd5, 1'b0, -1, 8'h00, 1'b1);

    reset_and_seed(1'b1, 8'h3C);

    for (int t = 0; t < 40; t++) begin
      lim_r = 8'($urandom_range(0, 255));
      for (int i = 0; i < MT; i++) begin
        stim[i] = 8'($urandom);
        if ($urandom_range(0, 2) == 0) stim[i] = stim[i] | 8'hE0;
      end
      apply_stimulus(lim_r, 1'b0, -1, 8'h00, 1'b0);
    end

    repeat (4) @(negedge clk);
    check_output("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_range_sampler.md
# rand_range_sampler

Consumer stage for the 8-bit LFSR random generator. It owns the generator's `load`/`seed` pins and seeds the generator after reset or on request. It turns the raw byte stream into uniformly distributed values in [0, limit) using masked rejection sampling, with a bounded retry count and a deterministic fallback. Game logic (spawn positions, pattern selection) requests one value at a time and gets a one-cycle valid pulse back.

## Interface
- `SEED`, 8'hF0: seed loaded into the generator after reset release.
- `MAX_TRIES`, 4: sampling attempts before fallback; legal range 1..15.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `rand` in 8: generator output; changes every clock unless loaded.
- `rand_load` out 1: drives generator `load`; registered one-cycle pulse.
- `rand_seed` out 8: drives generator `seed`; registered.
- `reseed` in 1: request reload of the generator with `seed_in`.
- `seed_in` in 8: new seed, sampled when `reseed` is high.
- `req` in 1: request one value; accepted only when `busy`=0.
- `limit` in 8: exclusive upper bound, sampled on accept; 0 means 256.
- `busy` out 1: high when state is not IDLE.
- `out_valid` out 1: one-cycle pulse, `value` is new.
- `value` out 8: result; held until the next result.

## Operation
- States:
  - SEED: pulse `rand_load` with `SEED`, then go to IDLE.
  - IDLE: wait for `req`.
  - SAMPLE: draw and test candidates until accept or fallback.
- Reset values:
  - state = SEED, `busy` = 1.
  - `rand_load` = 0, `rand_seed` = `SEED`.
  - `out_valid` = 0, `value` = 0.
  - try counter = 0, latched limit = 0, mask = 0.
- SEED: on the first edge after reset release:
  - `rand_load` <= 1 for one cycle, `rand_seed` <= `SEED`.
  - Next state IDLE.
  - `req` is ignored while in SEED.
- IDLE, `req`=1:
  - Latch `limit` as 9-bit L (0 becomes 256).
  - Compute mask = smallest 2^k−1 ≥ L−1, registered: L=1 gives 0, L=5 gives 7, L=128 gives 127, L=256 gives 255.
  - Clear the try counter and go to SAMPLE.
- SAMPLE, each cycle:
  - candidate = `rand` & mask; try counter increments.
  - Accept if candidate < L: `value` <= candidate, `out_valid` <= 1, go to IDLE.
  - Reject with counter < `MAX_TRIES`: stay in SAMPLE. The next cycle's `rand` is a fresh byte.
  - Reject on attempt `MAX_TRIES` (fallback): `value` <= candidate − L, `out_valid` <= 1, go to IDLE. The fallback is always < L because mask < 2L.
- `reseed`, handled in any state:
  - Next edge: `rand_load` <= 1, `rand_seed` <= `seed_in`.
  - If `seed_in` is 0, substitute 8'h01; the zero state locks the LFSR.
  - Does not change FSM state. A sample taken during the load cycle uses the pre-load `rand`.
  - Concurrent `req` in IDLE is still accepted.
- `reseed` during SEED: the reseed value wins over `SEED`.
- `req` while `busy`: ignored, not queued.
- Width rules: compare and subtract in 9 bits; `value` is the low 8 bits.

## Timing
- `req` accepted at edge k:
  - First attempt at edge k+1.
  - Best case: `out_valid` high in the cycle after edge k+1.
  - Worst case: `out_valid` after edge k+`MAX_TRIES`.
- Back-to-back: `busy` falls together with the `out_valid` edge. `req` held high is accepted on the next edge, giving one result at most every 2 cycles.
- `rand_load`: high for exactly one cycle per event. Two reseeds on consecutive cycles produce a two-cycle-wide pulse carrying the latest seed.
- `rst_n` low mid-SAMPLE:
  - Outputs return to reset values immediately.
  - No `out_valid` for the aborted request.
  - The SEED load repeats after release.

## Structure
- Shared package `izayoi_pkg`:
  - FSM state enum (SEED, IDLE, SAMPLE).
  - Function `rand_mask(limit)` returning the 8-bit mask.
  - Constant `RAND_ZERO_SUB` = 8'h01.
- No sub-module. The mask function is combinational and lives in the package.
- Top-level wiring: `rand` ← generator `rand`; generator `load`/`seed` ← `rand_load`/`rand_seed`.

## Test plan
- Reset, then release: `rand_load`=1 for one cycle with `rand_seed`=8'hF0; `busy` falls the following cycle.
- `limit`=5, bench drives `rand` = 0x07, 0x0E, 0x03 on successive attempts: two rejects (7, 6), then `value`=3 with `out_valid` 3 cycles after accept.
- `MAX_TRIES`=4, `limit`=5, `rand` held at 0x07: four rejects, then fallback `value`=2, `out_valid` after edge k+4.
- Range corners:
  - `limit`=0 with `rand`=0xFF gives `value`=0xFF on the first try.
  - `limit`=1 with any `rand` gives `value`=0.
  - `limit`=128 with `rand`=0xC5 gives `value`=0x45.
- `reseed` with `seed_in`=0x00 during SAMPLE:
  - `rand_seed`=0x01 and `rand_load` pulses once.
  - Sampling continues.
  - With the real generator attached, subsequent `rand` is 0x02, 0x04, …, 0x80, 0x71.
- `rst_n` asserted on the second SAMPLE cycle: `out_valid` never pulses, `value`=0, and the SEED load repeats after release.
